checkpoint_rename_table: RTL

- Next-generation register alias table for the scheduler rename stage.
- Indexed by architectural register: arch -> phys map plus per-preg ready bits.
- Adds CKPT_NUM branch checkpoints (circular buffer) for single-cycle mispredict recovery, and a committed map for full flush.
- Parametrised in decode width, writeback width, register counts and checkpoint depth.
- Sits between decode/FreeList and dispatch/ROB.

---
 rtl/checkpoint_rename_table.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/checkpoint_rename_table.sv
// checkpoint_rename_table
//   Register alias table for the rename stage. It holds a speculative
//   arch->phys map, a committed map, per-preg ready bits and a circular
//   buffer of CKPT_NUM branch checkpoints for single-cycle mispredict
//   recovery. Lookups are combinational, and state updates on posedge clk.
// Ports
//   clk, rst               clock, synchronous active-high reset
//   rename_valid_i ..      decode group: sources, dest, new preg, ckpt request
//   psrc*_o, ppdst_o ..    renamed sources, ready bits, previous dest mapping
//   ckpt_id_o              checkpoint slot assigned to each requesting lane
//   ckpt_ready_o           enough free slots for this group's requests
//   ckpt_count_o           occupied checkpoint slots
//   wb_i, wb_pdest_i       writeback ready-set ports
//   commit_*               committed map update ports
//   ckpt_release_i         pop oldest checkpoint
//   recover_i/recover_id_i restore a checkpoint
//   flush_i                restore committed map
module checkpoint_rename_table #(
  parameter int PHY_REG_NUM  = 64,
  parameter int ARCH_REG_NUM = 32,
  parameter int DECODE_WIDTH = 2,
  parameter int WB_WIDTH     = 4,
  parameter int COMMIT_WIDTH = 2,
  parameter int CKPT_NUM     = 4,
  localparam int PW = $clog2(PHY_REG_NUM),
  localparam int AW = $clog2(ARCH_REG_NUM),
  localparam int CW = $clog2(CKPT_NUM)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [DECODE_WIDTH-1:0]              rename_valid_i,
  input  logic [DECODE_WIDTH-1:0][AW-1:0]      src0_i,
  input  logic [DECODE_WIDTH-1:0][AW-1:0]      src1_i,
  input  logic [DECODE_WIDTH-1:0]              dest_valid_i,
  input  logic [DECODE_WIDTH-1:0][AW-1:0]      dest_i,
  input  logic [DECODE_WIDTH-1:0][PW-1:0]      preg_i,
  input  logic [DECODE_WIDTH-1:0]              ckpt_req_i,
  output logic [DECODE_WIDTH-1:0][PW-1:0]      psrc0_o,
  output logic [DECODE_WIDTH-1:0][PW-1:0]      psrc1_o,
  output logic [DECODE_WIDTH-1:0]              psrc0_ready_o,
  output logic [DECODE_WIDTH-1:0]              psrc1_ready_o,
  output logic [DECODE_WIDTH-1:0][PW-1:0]      ppdst_o,
  output logic [DECODE_WIDTH-1:0][CW-1:0]      ckpt_id_o,
  output logic                                 ckpt_ready_o,
  output logic [CW:0]                          ckpt_count_o,
  input  logic [WB_WIDTH-1:0]                  wb_i,
  input  logic [WB_WIDTH-1:0][PW-1:0]          wb_pdest_i,
  input  logic [COMMIT_WIDTH-1:0]              commit_i,
  input  logic [COMMIT_WIDTH-1:0][AW-1:0]      commit_dest_i,
  input  logic [COMMIT_WIDTH-1:0][PW-1:0]      commit_preg_i,
  input  logic                                 ckpt_release_i,
  input  logic                                 recover_i,
  input  logic [CW-1:0]                        recover_id_i,
  input  logic                                 flush_i
);

  localparam int RW = $clog2(DECODE_WIDTH + 1);

  typedef logic [PW-1:0] preg_t;

  preg_t spec_map_q   [ARCH_REG_NUM];
  preg_t spec_map_d   [ARCH_REG_NUM];
  preg_t commit_map_q [ARCH_REG_NUM];
  preg_t commit_map_d [ARCH_REG_NUM];
  preg_t ckpt_q       [CKPT_NUM][ARCH_REG_NUM];
  preg_t ckpt_d       [CKPT_NUM][ARCH_REG_NUM];
  preg_t work_map     [ARCH_REG_NUM];
  preg_t stage_map    [DECODE_WIDTH][ARCH_REG_NUM];

  logic [PHY_REG_NUM-1:0]  ready_q, ready_d, wb_vec, ready_eff;
  logic [CW-1:0]           head_q, head_d, tail_q, tail_d;
  logic [CW:0]             count_q, count_d;
  logic [DECODE_WIDTH-1:0] lane_wr, lane_ck;
  logic [RW-1:0]           req_cnt;
  logic                    rename_en, rel;
  logic [CW-1:0]           rec_dist;

  assign ckpt_count_o = count_q;

  always_comb begin
    for (int unsigned i = 0; i < DECODE_WIDTH; i++) begin
      lane_wr[i] = rename_valid_i[i] && dest_valid_i[i] && (dest_i[i] != '0);
      lane_ck[i] = rename_valid_i[i] && ckpt_req_i[i];
    end
  end

  // Same-cycle writeback bypass for the ready lookup.
  always_comb begin
    wb_vec = '0;
    for (int unsigned k = 0; k < WB_WIDTH; k++) begin
      if (wb_i[k]) wb_vec[wb_pdest_i[k]] = 1'b1;
    end
  end
  assign ready_eff = ready_q | wb_vec;

  // Source/dest lookup with intra-group RAW and WAW overrides; the inner
  // loop runs oldest to youngest so the youngest earlier writer wins.
  always_comb begin
    for (int unsigned i = 0; i < DECODE_WIDTH; i++) begin
      psrc0_o[i]       = spec_map_q[src0_i[i]];
      psrc1_o[i]       = spec_map_q[src1_i[i]];
      psrc0_ready_o[i] = ready_eff[spec_map_q[src0_i[i]]];
      psrc1_ready_o[i] = ready_eff[spec_map_q[src1_i[i]]];
      ppdst_o[i]       = spec_map_q[dest_i[i]];
      for (int unsigned j = 0; j < i; j++) begin
        if (lane_wr[j] && dest_i[j] == src0_i[i]) begin
          psrc0_o[i]       = preg_i[j];
          psrc0_ready_o[i] = 1'b0;
        end
        if (lane_wr[j] && dest_i[j] == src1_i[i]) begin
          psrc1_o[i]       = preg_i[j];
          psrc1_ready_o[i] = 1'b0;
        end
        if (lane_wr[j] && dest_i[j] == dest_i[i]) ppdst_o[i] = preg_i[j];
      end
      if (src0_i[i] == '0) begin
        psrc0_o[i]       = '0;
        psrc0_ready_o[i] = 1'b1;
      end
      if (src1_i[i] == '0) begin
        psrc1_o[i]       = '0;
        psrc1_ready_o[i] = 1'b1;
      end
    end
  end

  // Slot numbering follows request order within the group.
  always_comb begin
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < DECODE_WIDTH; i++) begin
      ckpt_id_o[i] = CW'((32'(tail_q) + n) % 32'(CKPT_NUM));
      if (lane_ck[i]) n = n + 1;
    end
    req_cnt = RW'(n);
  end

  assign ckpt_ready_o = (32'(CKPT_NUM) - 32'(count_q)) >= 32'(req_cnt);
  assign rename_en    = ckpt_ready_o && !recover_i && !flush_i;
  assign rel          = ckpt_release_i && (count_q != '0);
  assign rec_dist     = CW'((32'(recover_id_i) + 32'(CKPT_NUM) - 32'(head_q)) % 32'(CKPT_NUM));

  // Map as seen after each lane is applied; lane i's checkpoint captures
  // stage_map[i], so younger lanes in the same group are excluded.
  always_comb begin
    work_map = spec_map_q;
    for (int unsigned i = 0; i < DECODE_WIDTH; i++) begin
      if (lane_wr[i]) work_map[dest_i[i]] = preg_i[i];
      stage_map[i] = work_map;
    end
  end

  always_comb begin
    commit_map_d = commit_map_q;
    for (int unsigned c = 0; c < COMMIT_WIDTH; c++) begin
      if (commit_i[c] && commit_dest_i[c] != '0) commit_map_d[commit_dest_i[c]] = commit_preg_i[c];
    end
  end

  always_comb begin
    spec_map_d = spec_map_q;
    ckpt_d     = ckpt_q;
    ready_d    = ready_eff;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    if (flush_i) begin
      spec_map_d = commit_map_d;
      ready_d    = '1;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
    end else if (recover_i) begin
      spec_map_d = ckpt_q[recover_id_i];
      tail_d     = CW'((32'(recover_id_i) + 1) % 32'(CKPT_NUM));
      count_d    = (CW+1)'(32'(rec_dist) + 1 - 32'(rel));
      if (rel) head_d = CW'((32'(head_q) + 1) % 32'(CKPT_NUM));
    end else begin
      if (rel) head_d = CW'((32'(head_q) + 1) % 32'(CKPT_NUM));
      if (rename_en) begin
        spec_map_d = stage_map[DECODE_WIDTH-1];
        // Cleared after the writeback merge so allocation beats writeback.
        for (int unsigned i = 0; i < DECODE_WIDTH; i++) begin
          if (lane_wr[i]) ready_d[preg_i[i]] = 1'b0;
          if (lane_ck[i]) ckpt_d[ckpt_id_o[i]] = stage_map[i];
        end
        tail_d = CW'((32'(tail_q) + 32'(req_cnt)) % 32'(CKPT_NUM));
      end
      count_d = (CW+1)'(32'(count_q) + (rename_en ? 32'(req_cnt) : 32'd0) - 32'(rel));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned a = 0; a < ARCH_REG_NUM; a++) begin
        spec_map_q[a]   <= PW'(a);
        commit_map_q[a] <= PW'(a);
      end
      ready_q <= '1;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      spec_map_q   <= spec_map_d;
      commit_map_q <= commit_map_d;
      ready_q      <= ready_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
    end
  end

  // Checkpoint payload is only read after being written, so it needs no reset.
  always_ff @(posedge clk) begin
    ckpt_q <= ckpt_d;
  end

  a_recover_slot: assert property (@(posedge clk) disable iff (rst)
    (recover_i && !flush_i) |->
      ((32'(rec_dist) < 32'(count_q)) && !(ckpt_release_i && recover_id_i == head_q)));

endmodule
